// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_sync_ext #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int AFULL_LEVEL  = FIFO_DEPTH - 1,
  parameter  int AEMPTY_LEVEL = 1,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_val,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wp, rp;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_acc, rd_acc;

  // Explicit wrap so non-power-of-two depths never alias past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready     = (cnt != CNT_W'(FIFO_DEPTH));
  assign wr_acc       = wr_en && wr_ready;
  assign rd_acc       = rd_en && (cnt != '0);
  assign count        = cnt;
  assign almost_full  = (int'(cnt) >= AFULL_LEVEL);
  assign almost_empty = (int'(cnt) <= AEMPTY_LEVEL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wp <= ptr_inc(wp);
      if (rd_acc) rp <= ptr_inc(rp);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      overflow  <= wr_en && !wr_ready;
      underflow <= rd_en && (cnt == '0);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign rd_val  = (cnt != '0);
  assign rd_data = mem[rp];
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_val  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_val <= rd_acc;
      if (rd_acc) rd_data <= mem[rp];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Randomized scoreboard bench for fifo_sync_ext (depth 5) against a queue-based reference.
module tb_fifo_sync_ext;

  localparam int D  = 5;
  localparam int W  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, rd_en;
  logic [W-1:0]  wr_data;
  logic          wr_ready, rd_val, almost_full, almost_empty, overflow, underflow;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] mq[$];
  logic [W-1:0] exp_rd[$];
  bit           exp_ovf, exp_udf;
  bit           m_full, m_empty;

  fifo_sync_ext #(
    .DATA_WIDTH(W), .FIFO_DEPTH(D), .AFULL_LEVEL(D - 1), .AEMPTY_LEVEL(1)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_val(rd_val), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a plain queue; occupancy is its size.
  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      exp_rd.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      m_full  = (mq.size() == D);
      m_empty = (mq.size() == 0);
      exp_ovf = wr_en && m_full;
      exp_udf = rd_en && m_empty;
      if (rd_en && !m_empty) exp_rd.push_back(mq.pop_front());
      if (wr_en && !m_full) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), mq.size());
      chk("wr_ready", 32'(wr_ready), 32'(mq.size() != D));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= D - 1));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_udf));
`ifdef FIFO_FWFT_EN
      exp_rd.delete();
      chk("rd_val", 32'(rd_val), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
`else
      if (rd_val) begin
        if (exp_rd.size() == 0) chk("rd_val_spurious", 32'(rd_val), 0);
        else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
      end else if (exp_rd.size() != 0) begin
        chk("rd_val_missing", 32'(rd_val), 1);
        void'(exp_rd.pop_front());
      end
`endif
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_val", 32'(rd_val), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
`ifndef FIFO_FWFT_EN
    chk("rst_rd_data", 32'(rd_data), 0);
`endif
    mon_en = 1'b1;
    @(negedge clk) reset = 1'b1;

    // Fill, overflow, simultaneous at full, drain.
    for (int i = 0; i < D; i++) cyc(1, 0, W'(i));
    cyc(0, 0, 0);
    cyc(1, 0, 8'h09);
    cyc(0, 0, 0);
    cyc(1, 1, 8'h08);
    for (int i = 0; i < D; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);

    // Underflow, simultaneous at empty, then at count 2.
    cyc(0, 1, 0);
    cyc(1, 1, 8'h33);
    cyc(1, 0, 8'h44);
    cyc(1, 1, 8'h55);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);

    // Single word into an empty FIFO, then one pop.
    cyc(1, 0, 8'hA5);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    // Random traffic in fill-biased, drain-biased and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(99) < pw, $urandom_range(99) < pr, W'($urandom));
    end

    // Mid-operation asynchronous reset with three words held.
    for (int i = 0; i <= D; i++) cyc(0, 1, 0);
    cyc(1, 0, 8'h01);
    cyc(1, 0, 8'h02);
    cyc(1, 0, 8'h03);
    cyc(0, 0, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_count", 32'(count), 3);
    reset = 1'b0;
    mq.delete();
    exp_rd.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_rd_val", 32'(rd_val), 0);
    chk("async_rst_wr_ready", 32'(wr_ready), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    cyc(1, 0, 8'h77);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_ext.md
# fifo_sync_ext

Parametrised single-clock FIFO, the successor to the basic `fifo` buffer. Adds:
- any integer depth, not only powers of two;
- an occupancy count;
- programmable almost-full and almost-empty flags;
- overflow and underflow error pulses;
- a compile-time choice between registered-read and first-word-fall-through (FWFT) output.

It sits between producer and consumer stages in the datapath, wherever the plain `fifo` was used.

## Interface
- `DATA_WIDTH`, 8, word width in bits.
- `FIFO_DEPTH`, 4, number of entries; any integer ≥ 2.
- `AFULL_LEVEL`, `FIFO_DEPTH-1`, `almost_full` asserts when count ≥ this value.
- `AEMPTY_LEVEL`, 1, `almost_empty` asserts when count ≤ this value.
- `CNT_W`, `$clog2(FIFO_DEPTH+1)`, width of `count`; derived, not overridden.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `wr_en`  in  1  write request.
- `wr_data`  in  `DATA_WIDTH`  write word.
- `wr_ready`  out  1  FIFO can accept a write (not full).
- `rd_en`  in  1  read request / pop.
- `rd_data`  out  `DATA_WIDTH`  read word.
- `rd_val`  out  1  `rd_data` is valid (meaning depends on mode).
- `count`  out  `CNT_W`  current occupancy, 0..`FIFO_DEPTH`.
- `almost_full`  out  1  count ≥ `AFULL_LEVEL`.
- `almost_empty`  out  1  count ≤ `AEMPTY_LEVEL`.
- `overflow`  out  1  one-cycle pulse: write requested while full.
- `underflow`  out  1  one-cycle pulse: read requested while empty.

## Operation
- **Storage and pointers.** Storage is a `FIFO_DEPTH`-entry register array. It uses write pointer `wp`, read pointer `rp` and occupancy counter `cnt`.
- **Accepted write:** `wr_en && wr_ready`. It stores `wr_data` at `wp`.
- **Accepted read:** `rd_en && (cnt != 0)`. It advances `rp`.
- **Pointer wrap.** Each pointer increments modulo `FIFO_DEPTH`: from `FIFO_DEPTH-1` it goes to 0. There is no power-of-two aliasing.
- **Count update.** On each edge, `cnt` does +1 for a write only, −1 for a read only, and is unchanged for both or neither.
- **`wr_ready`** = (`cnt != FIFO_DEPTH`). It is a function of registered state only.
- **Full, simultaneous read and write:** the read is accepted and the write is rejected (no write-through). `overflow` pulses and `cnt` becomes `FIFO_DEPTH-1`.
- **Empty, simultaneous read and write:** the write is accepted and the read is rejected. `underflow` pulses and `cnt` becomes 1.
- **Rejected requests.** A rejected request never changes pointers or storage contents.
- **Flags.** `almost_full` and `almost_empty` decode from registered `cnt`. `count` = `cnt`.
- **`overflow` / `underflow`** are registered. Each pulses for one cycle in the cycle after the offending request.
- **Reset.** Asynchronous assertion clears `wp`, `rp`, `cnt`, `rd_val`, `rd_data`, `overflow` and `underflow` immediately.
  - Storage array contents are not reset.
  - A mid-operation reset discards all stored words.

## Timing
Reset values:

| Output | Reset value |
|---|---|
| `wr_ready` | 1 |
| `rd_val` | 0 |
| `rd_data` | 0 |
| `count` | 0 |
| `almost_full` | 0 (valid for `AFULL_LEVEL` ≥ 1) |
| `almost_empty` | 1 |
| `overflow` | 0 |
| `underflow` | 0 |

Latencies:
- **Write to `count`/flags:** 1 cycle.
- **Registered-read mode:**
  - `rd_data` is loaded and `rd_val` pulses high for exactly one cycle, on the edge after an accepted read.
  - `rd_data` holds its last value otherwise.
  - Read latency is 1 cycle.
- **FWFT mode:**
  - `rd_val` = (`cnt != 0`) and `rd_data` = `mem[rp]`, both continuously.
  - A write to an empty FIFO shows on `rd_data` with `rd_val = 1` one cycle after the write edge.
  - `rd_en` acts as a pop acknowledge. The next word appears the cycle after the pop.
- **Ready timing.** `wr_ready` deasserts in the cycle after the write that fills the FIFO. It reasserts in the cycle after the first read from full.

## Configuration
- `FIFO_FWFT_EN` defined: FWFT output as described above. `rd_data` is combinational from the array, with no output register.
- `FIFO_FWFT_EN` undefined (default): registered-read mode. `rd_data` is a dedicated register and `rd_val` is a one-cycle pulse per accepted read.
- All other behaviour is identical in both modes: pointers, count, flags and the error pulses.

## Test plan
- **Depth 4, default mode, in-order data.** Write 0, 1, 2, 3 on consecutive cycles, then `wr_en = 0`.
  - Expected: `count` reaches 4, `wr_ready = 0`, `almost_full = 1`.
  - Then `rd_en = 1` for 4 cycles. Expected: `rd_val` pulses with `rd_data` 0, 1, 2, 3 in order, each 1 cycle after its read. `count` returns to 0 and `almost_empty = 1`.
- **Overflow / underflow.**
  - Full FIFO plus `wr_en` with data 9: `overflow` pulses once, `count` stays 4, and 9 is never read.
  - Empty FIFO plus `rd_en`: `underflow` pulses once and `rd_val` stays 0.
- **Non-power-of-two depth (`FIFO_DEPTH = 5`).** Stream 12 words 0..11 with interleaved reads, keeping `count` ≤ 5. Expected: output order is exactly 0..11 across the pointer wrap at index 4 → 0.
- **Simultaneous read/write.**
  - At full (`count = 4`): write accepted = 0, `overflow` pulses, `count` becomes 3.
  - At empty: `count` becomes 1, `underflow` pulses.
  - At `count = 2`: `count` stays 2 and data order is preserved.
- **FWFT mode (`FIFO_FWFT_EN`).**
  - Write 0xA5 into an empty FIFO. Next cycle: `rd_val = 1`, `rd_data = 0xA5`.
  - Pulse `rd_en` for one cycle. Next cycle: `rd_val = 0` and `count = 0`.
- **Mid-operation reset.** Pull `reset` low asynchronously with `count = 3`, off a clock edge. Expected: immediately `count = 0`, `rd_val = 0`, `wr_ready = 1`. After release, a read returns only newly written data.
